spi_mem_arbiter: RTL and testbench

//  Shares the single-port 4096x8 SPI buffer memory between the spiifc read port and a host requester.
//  SPI reads have strict priority; the host performs reads and writes through a req/ack handshake.

---
 rtl/spi_mem_arbiter.sv | 117 +++++++++++
 tb/tb_spi_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Arbitrates one single-port buffer memory between SPI reads (strict priority) and a
// host req/ack port. Read data returns 2 cycles after grant; host starvation is flagged.
module spi_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 255
) (
  input  logic              SPI_CLK,
  input  logic              Reset,
  input  logic              SpiReq,
  input  logic [ADDR_W-1:0] SpiAddr,
  output logic              SpiValid,
  output logic [DATA_W-1:0] SpiData,
  input  logic              HostReq,
  input  logic              HostWe,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWrData,
  output logic              HostAck,
  output logic [DATA_W-1:0] HostRdData,
  output logic              HostStarved,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, H_ISSUE, H_ACK} state_t;
  typedef enum logic [1:0] {T_NONE, T_SPI, T_HRD, T_HWR} tag_t;

  state_t           r_state;
  tag_t             r_tag;
  logic [CNT_W-1:0] r_stall;

  logic             w_host_gnt;
  tag_t             w_tag;
  logic [CNT_W-1:0] w_stall_nxt;

  assign w_host_gnt = !SpiReq && HostReq && (r_state == IDLE);

  // Memory port is driven straight from the grant decision so reads issue the same cycle.
  always_comb begin
    MemEn     = !Reset && (SpiReq || w_host_gnt);
    MemWe     = !Reset && w_host_gnt && HostWe;
    MemAddr   = w_host_gnt ? HostAddr : SpiAddr;
    MemWrData = HostWrData;
  end

  always_comb begin
    w_tag = T_NONE;
    if (SpiReq)          w_tag = T_SPI;
    else if (w_host_gnt) w_tag = HostWe ? T_HWR : T_HRD;
  end

  always_comb begin
    w_stall_nxt = r_stall;
    if (!HostReq || w_host_gnt)
      w_stall_nxt = '0;
    else if (r_state == IDLE && SpiReq && r_stall != LIM)
      w_stall_nxt = r_stall + 1'b1;
  end

  // Owner tag follows the grant; the cycle after, memory data lands in the owner's register.
  always_ff @(posedge SPI_CLK) begin
    if (Reset) begin
      r_tag      <= T_NONE;
      SpiValid   <= 1'b0;
      SpiData    <= '0;
      HostRdData <= '0;
    end else begin
      r_tag    <= w_tag;
      SpiValid <= (r_tag == T_SPI);
      if (r_tag == T_SPI) SpiData    <= MemRdData;
      if (r_tag == T_HRD) HostRdData <= MemRdData;
    end
  end

  always_ff @(posedge SPI_CLK) begin
    if (Reset) begin
      r_state <= IDLE;
      HostAck <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          HostAck <= 1'b0;
          if (w_host_gnt) r_state <= H_ISSUE;
        end
        H_ISSUE: begin
          HostAck <= 1'b1;
          r_state <= H_ACK;
        end
        H_ACK: begin
          HostAck <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          HostAck <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge SPI_CLK) begin
    if (Reset) begin
      r_stall     <= '0;
      HostStarved <= 1'b0;
    end else begin
      r_stall     <= w_stall_nxt;
      HostStarved <= (w_stall_nxt == LIM);
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: stimulus pushes predicted responses,
// a negedge monitor pops and compares; a behavioural memory sits on the port.
module tb_spi_mem_arbiter;

  logic        SPI_CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        SpiReq = 1'b0;
  logic [11:0] SpiAddr = '0;
  logic        SpiValid;
  logic [7:0]  SpiData;
  logic        HostReq = 1'b0;
  logic        HostWe = 1'b0;
  logic [11:0] HostAddr = '0;
  logic [7:0]  HostWrData = '0;
  logic        HostAck;
  logic [7:0]  HostRdData;
  logic        HostStarved;
  logic        MemEn, MemWe;
  logic [11:0] MemAddr;
  logic [7:0]  MemWrData;
  logic [7:0]  MemRdData = '0;

  spi_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(255)) dut (
    .SPI_CLK(SPI_CLK), .Reset(Reset),
    .SpiReq(SpiReq), .SpiAddr(SpiAddr), .SpiValid(SpiValid), .SpiData(SpiData),
    .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWrData(HostWrData),
    .HostAck(HostAck), .HostRdData(HostRdData), .HostStarved(HostStarved),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  int cyc = 0;
  always @(posedge SPI_CLK) cyc <= cyc + 1;

  // Behavioural single-port memory, read-before-write, data valid the cycle after MemEn.
  logic [7:0] mem [4096];
  always @(posedge SPI_CLK) begin
    if (MemEn) begin
      MemRdData <= mem[MemAddr];
      if (MemWe) mem[MemAddr] = MemWrData;
    end
  end

  typedef struct {int cyc; logic [7:0] d; bit rd;} exp_t;
  exp_t spi_q[$], host_q[$], star_q[$];
  exp_t mon_e;
  logic [7:0] ref_mem [4096];
  logic [7:0] last_hrd = '0;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest prediction, on the predicted cycle.
  always @(negedge SPI_CLK) begin
    if (Reset) last_hrd = '0;
    if (SpiValid) begin
      if (spi_q.size() == 0) check("spi_unexpected_valid", 1, 0);
      else begin
        mon_e = spi_q.pop_front();
        check("spi_valid_cycle", cyc, mon_e.cyc);
        check("spi_data", {24'd0, SpiData}, {24'd0, mon_e.d});
      end
    end else if (spi_q.size() > 0 && spi_q[0].cyc <= cyc) begin
      mon_e = spi_q.pop_front();
      check("spi_missing_valid", 0, 1);
    end
    if (HostAck) begin
      if (host_q.size() == 0) check("host_unexpected_ack", 1, 0);
      else begin
        mon_e = host_q.pop_front();
        check("host_ack_cycle", cyc, mon_e.cyc);
        if (mon_e.rd) begin
          check("host_rd_data", {24'd0, HostRdData}, {24'd0, mon_e.d});
          last_hrd = mon_e.d;
        end else
          check("host_wr_keeps_rdata", {24'd0, HostRdData}, {24'd0, last_hrd});
      end
    end else if (host_q.size() > 0 && host_q[0].cyc <= cyc) begin
      mon_e = host_q.pop_front();
      check("host_missing_ack", 0, 1);
    end
    while (star_q.size() > 0 && star_q[0].cyc <= cyc) begin
      mon_e = star_q.pop_front();
      check("host_starved", {31'd0, HostStarved}, {31'd0, mon_e.d[0]});
    end
  end

  // Host requester state kept by the bench
  bit         h_active = 0, h_gnt = 0, h_pend = 0;
  int         h_gcyc = 0;
  bit         p_we;
  logic [11:0] p_addr;
  logic [7:0]  p_wd;
  int         stall = 0;

  task automatic host_issue(input bit we, input logic [11:0] a, input logic [7:0] wd);
    p_we = we; p_addr = a; p_wd = wd; h_pend = 1;
  endtask

  // One clock cycle: apply inputs, predict outcome from the arbitration rules, advance.
  task automatic cycle(input bit spi, input logic [11:0] sa);
    exp_t e;
    if (h_active && h_gnt && cyc >= h_gcyc + 3) h_active = 0;
    if (!h_active && h_pend) begin
      HostWe = p_we; HostAddr = p_addr; HostWrData = p_wd;
      h_active = 1; h_gnt = 0; h_pend = 0;
    end
    HostReq = h_active;
    SpiReq = spi; SpiAddr = sa;
    if (spi) begin
      e.cyc = cyc + 2; e.d = ref_mem[sa]; e.rd = 1;
      spi_q.push_back(e);
    end else if (h_active && !h_gnt) begin
      h_gnt = 1; h_gcyc = cyc;
      e.cyc = cyc + 2; e.d = ref_mem[HostAddr]; e.rd = !HostWe;
      host_q.push_back(e);
      if (HostWe) ref_mem[HostAddr] = HostWrData;
    end
    if (h_active && !h_gnt && spi) stall = (stall < 255) ? stall + 1 : 255;
    else stall = 0;
    e.cyc = cyc + 1; e.d = {7'd0, stall == 255}; e.rd = 0;
    star_q.push_back(e);
    @(posedge SPI_CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 12'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    // Reset held 3 cycles with an SPI request pending: memory port must stay quiet
    Reset = 1; SpiReq = 1; SpiAddr = 12'h005;
    repeat (3) @(posedge SPI_CLK);
    #1;
    check("rst_SpiValid", {31'd0, SpiValid}, 0);
    check("rst_HostAck", {31'd0, HostAck}, 0);
    check("rst_HostStarved", {31'd0, HostStarved}, 0);
    check("rst_SpiData", {24'd0, SpiData}, 0);
    check("rst_HostRdData", {24'd0, HostRdData}, 0);
    check("rst_MemEn", {31'd0, MemEn}, 0);
    check("rst_MemWe", {31'd0, MemWe}, 0);
    Reset = 0; SpiReq = 0;

    // Single SPI read
    mem[5] = 8'hA5; ref_mem[5] = 8'hA5;
    cycle(1, 12'h005);
    idle(3);

    // Back-to-back SPI reads
    for (int i = 0; i < 4; i++) begin
      mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) cycle(1, 12'(i));
    idle(3);

    // Host write then read back
    host_issue(1, 12'h010, 8'h3C);
    idle(4);
    host_issue(0, 12'h010, 8'h00);
    idle(5);

    // Starvation: SPI hogs the port for 300 cycles, then releases
    host_issue(0, 12'h123, 8'h00);
    for (int i = 0; i < 300; i++) cycle(1, 12'($urandom));
    idle(6);

    // Reset while the host read is in H_ISSUE
    host_issue(0, 12'h200, 8'h00);
    cycle(0, 12'h0);
    Reset = 1; SpiReq = 1; HostReq = 0;
    spi_q.delete(); host_q.delete(); star_q.delete();
    h_active = 0; h_gnt = 0; h_pend = 0; stall = 0;
    check("rstmid_MemEn", {31'd0, MemEn}, 0);
    check("rstmid_MemWe", {31'd0, MemWe}, 0);
    repeat (2) @(posedge SPI_CLK);
    #1;
    Reset = 0; SpiReq = 0;
    idle(2);
    host_issue(0, 12'h200, 8'h00);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!h_active && !h_pend && $urandom_range(0, 2) == 0)
        host_issue(1'($urandom), 12'($urandom_range(0, 31)), 8'($urandom));
      cycle($urandom_range(0, 9) < 6, 12'($urandom_range(0, 31)));
    end
    idle(8);

    check("spi_q_drained", spi_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
